mem_arbiter: RTL



---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_access_timer.sv | 33 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids
// and the round-robin grant rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_e;
  typedef enum logic {REQ_CPU, REQ_LDR} requester_e;

  // A lone requester always wins; on a tie the one not granted last time wins.
  function automatic requester_e pick_grant(input logic cpu_req,
                                            input logic ldr_req,
                                            input requester_e last_grant);
    requester_e g;
    if (cpu_req && (!ldr_req || last_grant == REQ_LDR)) g = REQ_CPU;
    else g = REQ_LDR;
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_access_timer.sv
// Saturating wait counter for one memory access. done goes high once the
// count has reached TIMEOUT; with TIMEOUT=0 the timeout is disabled.
module access_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign done = 1'b0;
    end else begin : g_on
      localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);
      logic [TW-1:0] count;

      // Count not-ready cycles, holding at LIMIT so the counter never wraps.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable && count != LIMIT) count <= count + 1'b1;
      end

      assign done = (count == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU datapath and
// the loader/debug port. The granted request is latched for the whole
// access; completion is a one-cycle ack (with err on timeout).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  cpu_stall,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  output logic                  ldr_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  busy
);

  arb_state_e            state;
  requester_e            owner;
  requester_e            last_grant;
  requester_e            grant;
  logic                  timer_done;
  logic [DATA_WIDTH-1:0] fin_rdata;

  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (state == ACCESS && !mem_ready),
    .done   (timer_done)
  );

  assign grant     = pick_grant(cpu_req, ldr_req, last_grant);
  // Writes and timeouts return zero; only a completed read returns memory data.
  assign fin_rdata = (mem_ready && !mem_we) ? mem_rdata : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // Arbitration FSM; mem_* fields double as the latched request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= REQ_CPU;
      last_grant <= REQ_LDR;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_ack    <= 1'b0;
      ldr_err    <= 1'b0;
      ldr_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            if (grant == REQ_CPU) begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end else begin
              mem_we    <= ldr_we;
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
            end
            owner      <= grant;
            last_grant <= grant;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready wins over a timeout landing on the same edge.
          if (mem_ready || timer_done) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == REQ_CPU) begin
              cpu_ack   <= 1'b1;
              cpu_err   <= !mem_ready;
              cpu_rdata <= fin_rdata;
            end else begin
              ldr_ack   <= 1'b1;
              ldr_err   <= !mem_ready;
              ldr_rdata <= fin_rdata;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cpu_ack   <= 1'b0;
          cpu_err   <= 1'b0;
          cpu_rdata <= '0;
          ldr_ack   <= 1'b0;
          ldr_err   <= 1'b0;
          ldr_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
